// File: rtl/decoder_seq_pkg.sv
// decoder_sequencer shared definitions.
// Mode encodings and sweep FSM states.
package decoder_seq_pkg;

    localparam logic [1:0] MODE_DIRECT    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
    localparam logic [1:0] MODE_SWEEP     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_sequencer_onehot_dec.sv
// Combinational index to one-hot decode.
// Output is all-zero when en is low.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      idx,
    output logic [2**SEL_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/decoder_sequencer.sv
// Registered one-hot decoder with scan and sweep sequencing.
// All outputs come straight from flops.
module decoder_sequencer
    import decoder_seq_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                start,
    output logic [2**SEL_W-1:0] dout,
    output logic [SEL_W-1:0]    idx,
    output logic                busy,
    output logic                done
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]    DW_LAST = DW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    state_e              st_q, st_d;
    logic [SEL_W-1:0]    idx_d;
    logic [DW-1:0]       dwell_q, dwell_d, eff;
    logic [1:0]          mode_q, mode_d;
    logic                busy_d, done_d, on_d;
    logic                hold_q, hold_d;
    logic                last;
    logic [2**SEL_W-1:0] dout_d;

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .en     (on_d),
        .idx    (idx_d),
        .onehot (dout_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            idx     <= '0;
            dwell_q <= '0;
            mode_q  <= MODE_DIRECT;
            busy    <= 1'b0;
            done    <= 1'b0;
            hold_q  <= 1'b0;
            dout    <= '0;
        end else begin
            st_q    <= st_d;
            idx     <= idx_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            busy    <= busy_d;
            done    <= done_d;
            hold_q  <= hold_d;
            dout    <= dout_d;
        end
    end

    // A mode change restarts the dwell count; the first edge after
    // en returns only re-lights dout without advancing.
    always_comb begin
        st_d    = st_q;
        idx_d   = idx;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        busy_d  = busy;
        done_d  = 1'b0;
        on_d    = 1'b0;
        hold_d  = 1'b0;
        eff     = (mode != mode_q) ? '0 : dwell_q;
        last    = (eff == DW_LAST);
        if (!en) begin
            hold_d = 1'b1;
        end else begin
            mode_d = mode;
            if (st_q == ST_FIN) st_d = ST_IDLE;
            if (st_q == ST_RUN && mode != MODE_SWEEP) begin
                st_d   = ST_IDLE;
                busy_d = 1'b0;
            end
            unique case (mode)
                MODE_DIRECT: begin
                    idx_d   = sel;
                    dwell_d = '0;
                    on_d    = 1'b1;
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    on_d = 1'b1;
                    if (hold_q) begin
                        dwell_d = eff;
                    end else if (last) begin
                        idx_d   = (mode == MODE_SCAN_UP) ?
                                  idx + 1'b1 : idx - 1'b1;
                        dwell_d = '0;
                    end else begin
                        dwell_d = eff + 1'b1;
                    end
                end
                MODE_SWEEP: begin
                    unique case (st_q)
                        ST_IDLE: begin
                            if (start) begin
                                idx_d   = '0;
                                dwell_d = '0;
                                on_d    = 1'b1;
                                busy_d  = 1'b1;
                                st_d    = ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            on_d = 1'b1;
                            if (!hold_q && last) begin
                                if (idx == IDX_MAX) begin
                                    on_d   = 1'b0;
                                    busy_d = 1'b0;
                                    done_d = 1'b1;
                                    st_d   = ST_FIN;
                                end else begin
                                    idx_d   = idx + 1'b1;
                                    dwell_d = '0;
                                end
                            end else if (!hold_q) begin
                                dwell_d = eff + 1'b1;
                            end
                        end
                        default: begin
                            on_d = 1'b0;
                            st_d = ST_IDLE;
                        end
                    endcase
                end
                default: on_d = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_sequencer.sv
// Scoreboard bench for decoder_sequencer.
// Two instances: SEL_W=2/DWELL=2 and SEL_W=3/DWELL=1.
module tb_decoder_sequencer;

    typedef struct {
        int idx;
        int dw;
        int k;
        int busy;
        int done;
        int fin;
        int dout;
        int pmode;
        int resume;
    } m_t;

    typedef struct {
        int dout;
        int idx;
        int busy;
        int done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] sel = 3'd0;
    logic       start = 1'b0;

    logic [3:0] d0_dout;
    logic [1:0] d0_idx;
    logic       d0_busy, d0_done;
    logic [7:0] d1_dout;
    logic [2:0] d1_idx;
    logic       d1_busy, d1_done;

    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    m_t   m0, m1;

    always #5 clk = ~clk;

    decoder_sequencer #(.SEL_W(2), .DWELL(2)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel(sel[1:0]), .start(start),
        .dout(d0_dout), .idx(d0_idx), .busy(d0_busy), .done(d0_done)
    );

    decoder_sequencer #(.SEL_W(3), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel(sel), .start(start),
        .dout(d1_dout), .idx(d1_idx), .busy(d1_busy), .done(d1_done)
    );

    // Reference: a sweep is tracked as k elapsed steps, idx = k / d.
    function automatic m_t step(m_t s, int n, int d, bit r, bit e,
                                int md, int sl, bit st);
        m_t x;
        int dw;
        x = s;
        x.done = 0;
        if (!r) begin
            x = '{default: 0};
            return x;
        end
        if (!e) begin
            x.dout = 0;
            x.resume = 1;
            return x;
        end
        x.resume = 0;
        x.pmode = md;
        x.fin = 0;
        if (s.busy != 0 && md != 3) x.busy = 0;
        dw = (md != s.pmode) ? 0 : s.dw;
        case (md)
            0: begin
                x.idx = sl;
                x.dw = 0;
                x.dout = 1 << sl;
            end
            1, 2: begin
                if (s.resume != 0) begin
                    x.dw = dw;
                end else if (dw == d - 1) begin
                    x.idx = (md == 1) ? (s.idx + 1) % n : (s.idx + n - 1) % n;
                    x.dw = 0;
                end else begin
                    x.dw = dw + 1;
                end
                x.dout = 1 << x.idx;
            end
            default: begin
                if (s.busy != 0) begin
                    if (s.resume == 0) x.k = s.k + 1;
                    if (x.k == n * d) begin
                        x.busy = 0;
                        x.done = 1;
                        x.fin = 1;
                        x.dout = 0;
                        x.idx = n - 1;
                    end else begin
                        x.idx = x.k / d;
                        x.dw = x.k % d;
                        x.dout = 1 << x.idx;
                    end
                end else if (s.fin != 0) begin
                    x.dout = 0;
                end else if (st) begin
                    x.busy = 1;
                    x.k = 0;
                    x.idx = 0;
                    x.dw = 0;
                    x.dout = 1;
                end else begin
                    x.dout = 0;
                end
            end
        endcase
        return x;
    endfunction

    task automatic drive(bit r, bit e, int md, int sl, bit st);
        exp_t x;
        rst_n = r;
        en = e;
        mode = md[1:0];
        sel = sl[2:0];
        start = st;
        m0 = step(m0, 4, 2, r, e, md, sl & 3, st);
        x = '{m0.dout, m0.idx, m0.busy, m0.done};
        q0.push_back(x);
        m1 = step(m1, 8, 1, r, e, md, sl & 7, st);
        x = '{m1.dout, m1.idx, m1.busy, m1.done};
        q1.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string nm, exp_t x, int dv, int iv, int bv, int nv);
        tests++;
        if (dv != x.dout || iv != x.idx || bv != x.busy || nv != x.done) begin
            failures++;
            $display("FAIL %s cyc %0d: got dout=%0h idx=%0d busy=%0d done=%0d, want dout=%0h idx=%0d busy=%0d done=%0d",
                     nm, cyc, dv, iv, bv, nv, x.dout, x.idx, x.busy, x.done);
        end
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        cyc++;
        if (q0.size() > 0) begin
            x = q0.pop_front();
            chk("u0", x, int'(d0_dout), int'(d0_idx), int'(d0_busy), int'(d0_done));
        end
        if (q1.size() > 0) begin
            x = q1.pop_front();
            chk("u1", x, int'(d1_dout), int'(d1_idx), int'(d1_busy), int'(d1_done));
        end
    end

    initial begin
        int cm;
        int wait_n;
        m0 = '{default: 0};
        m1 = '{default: 0};
        #2;
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 3, 0, 1);
        drive(1, 1, 0, 2, 0);
        drive(1, 1, 0, 3, 0);
        repeat (4) drive(1, 1, 1, 3, 0);
        drive(1, 1, 0, 0, 0);
        repeat (4) drive(1, 1, 2, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (3) drive(1, 1, 1, 0, 0);
        repeat (3) drive(1, 0, 1, 0, 0);
        repeat (3) drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 3, 0, 1);
        repeat (3) drive(1, 1, 3, 0, 0);
        drive(1, 1, 3, 0, 1);
        repeat (6) drive(1, 1, 3, 0, 0);
        drive(1, 1, 3, 0, 1);
        drive(1, 1, 3, 0, 1);
        repeat (10) drive(1, 1, 3, 0, 0);
        drive(1, 1, 3, 0, 1);
        repeat (2) drive(1, 1, 3, 0, 0);
        repeat (2) drive(1, 1, 0, 1, 0);
        drive(1, 1, 3, 0, 1);
        repeat (4) drive(1, 1, 3, 0, 0);
        drive(0, 1, 3, 0, 0);
        repeat (2) drive(1, 1, 3, 0, 0);
        cm = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) cm = int'($urandom_range(3));
            drive($urandom_range(63) != 0, $urandom_range(7) != 0, cm,
                  int'($urandom_range(7)), $urandom_range(3) == 0);
        end
        wait_n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && wait_n < 10) begin
            @(posedge clk);
            #2;
            wait_n++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            tests++;
            failures++;
            $display("FAIL drain: %0d/%0d entries left, want 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
